rk_interrupt_controller: RTL and testbench

- Interrupt controller for the RK2040 core. It watches the 24 general-purpose input port lines and turns any toggle on an enabled line into a latched pending interrupt.
- It picks the highest-priority pending line and presents it to the core through a request/acknowledge/done handshake.
- It sits between `inputPort` and the core's exception logic. One interrupt is in service at a time; there is no nesting.

---
 rtl/rk_interrupt_controller.sv | 130 +++++++++++++
 tb/tb_rk_interrupt_controller.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rk_interrupt_controller.sv
// rtl/rk_interrupt_controller.sv - edge-triggered fixed-priority interrupt controller with req/ack/done handshake
module rk_interrupt_controller #(
    parameter int                 NUM_IRQ    = 24,
    parameter int                 IDX_W      = 5,
    parameter logic [NUM_IRQ-1:0] MASK_RESET = 24'hFFFFFF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               gie,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    output logic               irq_req,
    output logic [IDX_W-1:0]   irq_id,
    input  logic               irq_ack,
    input  logic               irq_done,
    output logic               in_service,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] mask
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    logic [NUM_IRQ-1:0] sync1_q, sync1_d;
    logic [NUM_IRQ-1:0] sync2_q, sync2_d;
    logic [NUM_IRQ-1:0] hist_q, hist_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [1:0]         state_q, state_d;
    logic               irq_req_q, irq_req_d;
    logic [IDX_W-1:0]   irq_id_q, irq_id_d;
    logic               in_service_q, in_service_d;

    logic [NUM_IRQ-1:0] evt;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] clr;
    logic [IDX_W-1:0]   win_idx;

    always_comb begin
        sync1_d  = irq_in;
        sync2_d  = sync1_q;
        hist_d   = sync2_q;
        evt      = sync2_q ^ hist_q;
        eligible = gie ? (pending_q & mask_q) : '0;

        // Descending scan so the lowest eligible index is the last assignment.
        win_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_idx = IDX_W'(i);
            end
        end

        clr          = '0;
        state_d      = state_q;
        irq_req_d    = irq_req_q;
        irq_id_d     = irq_id_q;
        in_service_d = in_service_q;
        mask_d       = mask_we ? mask_wdata : mask_q;

        case (state_q)
            ST_IDLE: begin
                if (|eligible) begin
                    irq_id_d  = win_idx;
                    irq_req_d = 1'b1;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                // A request that lost its enable is withdrawn even if acked in the same cycle.
                if (!mask_q[irq_id_q] || !gie) begin
                    irq_req_d = 1'b0;
                    state_d   = ST_IDLE;
                end else if (irq_ack) begin
                    clr[irq_id_q] = 1'b1;
                    irq_req_d     = 1'b0;
                    in_service_d  = 1'b1;
                    state_d       = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (irq_done) begin
                    in_service_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                irq_req_d    = 1'b0;
                in_service_d = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase

        // A fresh edge on the acked line outranks its clear.
        pending_d = (pending_q & ~clr) | evt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q      <= irq_in;
            sync2_q      <= irq_in;
            hist_q       <= irq_in;
            pending_q    <= '0;
            mask_q       <= MASK_RESET;
            state_q      <= ST_IDLE;
            irq_req_q    <= 1'b0;
            irq_id_q     <= '0;
            in_service_q <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            hist_q       <= hist_d;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            state_q      <= state_d;
            irq_req_q    <= irq_req_d;
            irq_id_q     <= irq_id_d;
            in_service_q <= in_service_d;
        end
    end

    assign irq_req    = irq_req_q;
    assign irq_id     = irq_id_q;
    assign in_service = in_service_q;
    assign pending    = pending_q;
    assign mask       = mask_q;

endmodule

// File: tb/tb_rk_interrupt_controller.sv
// tb/tb_rk_interrupt_controller.sv - directed self-checking bench for rk_interrupt_controller
module tb_rk_interrupt_controller;

    logic        clk;
    logic        rst;
    logic [23:0] irq_in;
    logic        gie;
    logic        mask_we;
    logic [23:0] mask_wdata;
    logic        irq_req;
    logic [4:0]  irq_id;
    logic        irq_ack;
    logic        irq_done;
    logic        in_service;
    logic [23:0] pending;
    logic [23:0] mask;

    int errors = 0;
    int checks = 0;

    rk_interrupt_controller dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .gie        (gie),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .irq_req    (irq_req),
        .irq_id     (irq_id),
        .irq_ack    (irq_ack),
        .irq_done   (irq_done),
        .in_service (in_service),
        .pending    (pending),
        .mask       (mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
    endtask

    task automatic pulse_done();
        irq_done = 1'b1;
        step(1);
        irq_done = 1'b0;
    endtask

    task automatic write_mask(input logic [23:0] v);
        mask_we    = 1'b1;
        mask_wdata = v;
        step(1);
        mask_we    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; irq_in = 24'h000020; gie = 1'b1;
        mask_we = 1'b0; mask_wdata = '0; irq_ack = 1'b0; irq_done = 1'b0;
        step(3);
        rst = 1'b1;
        step(20);
        checks++; if (pending !== 24'h0) begin errors++; $display("FAIL reset_pending got=%h exp=%h", pending, 24'h0); end
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", irq_req); end
        checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL reset_insvc got=%b exp=0", in_service); end
        checks++; if (mask !== 24'hFFFFFF) begin errors++; $display("FAIL reset_mask got=%h exp=ffffff", mask); end
        checks++; if (irq_id !== 5'd0) begin errors++; $display("FAIL reset_id got=%0d exp=0", irq_id); end
    endtask

    task automatic test_basic();
        irq_in[5] = ~irq_in[5];
        step(2);
        checks++; if (pending !== 24'h0) begin errors++; $display("FAIL basic_pend_early got=%h exp=0", pending); end
        step(1);
        checks++; if (pending !== 24'h000020) begin errors++; $display("FAIL basic_pend got=%h exp=000020", pending); end
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL basic_req_early got=%b exp=0", irq_req); end
        step(1);
        checks++; if (irq_req !== 1'b1) begin errors++; $display("FAIL basic_req got=%b exp=1", irq_req); end
        checks++; if (irq_id !== 5'd5) begin errors++; $display("FAIL basic_id got=%0d exp=5", irq_id); end
        pulse_ack();
        checks++; if (pending !== 24'h0) begin errors++; $display("FAIL basic_ack_pend got=%h exp=0", pending); end
        checks++; if (in_service !== 1'b1) begin errors++; $display("FAIL basic_insvc got=%b exp=1", in_service); end
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL basic_ack_req got=%b exp=0", irq_req); end
    endtask

    task automatic test_service_arrival();
        irq_in[7] = ~irq_in[7];
        step(3);
        checks++; if (pending !== 24'h000080) begin errors++; $display("FAIL svc_pend got=%h exp=000080", pending); end
        step(1);
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL svc_req_held got=%b exp=0", irq_req); end
        checks++; if (irq_id !== 5'd5) begin errors++; $display("FAIL svc_id_hold got=%0d exp=5", irq_id); end
        pulse_done();
        checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL svc_done got=%b exp=0", in_service); end
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL svc_idle_gap got=%b exp=0", irq_req); end
        step(1);
        checks++; if (irq_req !== 1'b1) begin errors++; $display("FAIL svc_next_req got=%b exp=1", irq_req); end
        checks++; if (irq_id !== 5'd7) begin errors++; $display("FAIL svc_next_id got=%0d exp=7", irq_id); end
        pulse_ack();
        pulse_done();
        step(1);
    endtask

    task automatic test_priority();
        irq_in[7] = ~irq_in[7];
        irq_in[3] = ~irq_in[3];
        step(3);
        checks++; if (pending !== 24'h000088) begin errors++; $display("FAIL prio_pend got=%h exp=000088", pending); end
        step(1);
        checks++; if (irq_id !== 5'd3 || irq_req !== 1'b1) begin errors++; $display("FAIL prio_first got id=%0d req=%b exp id=3 req=1", irq_id, irq_req); end
        pulse_ack();
        checks++; if (pending !== 24'h000080) begin errors++; $display("FAIL prio_ack_pend got=%h exp=000080", pending); end
        pulse_done();
        step(1);
        checks++; if (irq_id !== 5'd7 || irq_req !== 1'b1) begin errors++; $display("FAIL prio_second got id=%0d req=%b exp id=7 req=1", irq_id, irq_req); end
        pulse_ack();
        pulse_done();
        step(1);
    endtask

    task automatic test_mask();
        write_mask(24'hFFFF7F);
        checks++; if (mask !== 24'hFFFF7F) begin errors++; $display("FAIL mask_wr got=%h exp=ffff7f", mask); end
        irq_in[7] = ~irq_in[7];
        step(5);
        checks++; if (pending !== 24'h000080) begin errors++; $display("FAIL mask_pend got=%h exp=000080", pending); end
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL mask_noreq got=%b exp=0", irq_req); end
        write_mask(24'hFFFFFF);
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL mask_oldmask got=%b exp=0", irq_req); end
        step(1);
        checks++; if (irq_req !== 1'b1 || irq_id !== 5'd7) begin errors++; $display("FAIL mask_unmask got req=%b id=%0d exp req=1 id=7", irq_req, irq_id); end
        pulse_ack();
        pulse_done();
        step(1);
    endtask

    task automatic test_illegal();
        pulse_ack();
        pulse_done();
        checks++; if (in_service !== 1'b0 || irq_req !== 1'b0) begin errors++; $display("FAIL illegal_idle got insvc=%b req=%b exp 0 0", in_service, irq_req); end
        irq_in[4] = ~irq_in[4];
        step(4);
        irq_ack = 1'b1; irq_done = 1'b1;
        step(1);
        irq_ack = 1'b0; irq_done = 1'b0;
        checks++; if (in_service !== 1'b1 || pending !== 24'h0) begin errors++; $display("FAIL illegal_both_req got insvc=%b pend=%h exp 1 000000", in_service, pending); end
        irq_ack = 1'b1; irq_done = 1'b1;
        step(1);
        irq_ack = 1'b0; irq_done = 1'b0;
        checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL illegal_both_svc got=%b exp=0", in_service); end
        step(1);
    endtask

    task automatic test_gie_withdraw();
        irq_in[1] = ~irq_in[1];
        step(4);
        checks++; if (irq_req !== 1'b1 || irq_id !== 5'd1) begin errors++; $display("FAIL gie_req got req=%b id=%0d exp 1 1", irq_req, irq_id); end
        gie = 1'b0;
        step(1);
        checks++; if (irq_req !== 1'b0 || pending !== 24'h000002) begin errors++; $display("FAIL gie_withdraw got req=%b pend=%h exp 0 000002", irq_req, pending); end
        gie = 1'b1;
        step(1);
        checks++; if (irq_req !== 1'b1 || irq_id !== 5'd1) begin errors++; $display("FAIL gie_rereq got req=%b id=%0d exp 1 1", irq_req, irq_id); end
        pulse_ack();
        pulse_done();
        step(1);
    endtask

    task automatic test_back_to_back();
        irq_in[5] = ~irq_in[5];
        step(2);
        irq_in[5] = ~irq_in[5];
        step(1);
        checks++; if (pending !== 24'h000020) begin errors++; $display("FAIL b2b_pend got=%h exp=000020", pending); end
        step(1);
        checks++; if (irq_req !== 1'b1 || irq_id !== 5'd5) begin errors++; $display("FAIL b2b_req got req=%b id=%0d exp 1 5", irq_req, irq_id); end
        pulse_ack();
        checks++; if (pending !== 24'h000020 || in_service !== 1'b1) begin errors++; $display("FAIL b2b_evt_wins got pend=%h insvc=%b exp 000020 1", pending, in_service); end
        pulse_done();
        step(1);
        checks++; if (irq_req !== 1'b1 || irq_id !== 5'd5) begin errors++; $display("FAIL b2b_second got req=%b id=%0d exp 1 5", irq_req, irq_id); end
        pulse_ack();
        checks++; if (pending !== 24'h0 || in_service !== 1'b1) begin errors++; $display("FAIL b2b_second_ack got pend=%h insvc=%b exp 000000 1", pending, in_service); end
        write_mask(24'hFFFFFE);
        irq_in[2] = ~irq_in[2];
        step(3);
        checks++; if (pending !== 24'h000004) begin errors++; $display("FAIL b2b_pre_rst_pend got=%h exp=000004", pending); end
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        checks++; if (irq_req !== 1'b0 || in_service !== 1'b0 || irq_id !== 5'd0) begin errors++; $display("FAIL rst_mid_ctl got req=%b insvc=%b id=%0d exp 0 0 0", irq_req, in_service, irq_id); end
        checks++; if (pending !== 24'h0 || mask !== 24'hFFFFFF) begin errors++; $display("FAIL rst_mid_regs got pend=%h mask=%h exp 000000 ffffff", pending, mask); end
        step(5);
        checks++; if (pending !== 24'h0 || irq_req !== 1'b0) begin errors++; $display("FAIL rst_mid_quiet got pend=%h req=%b exp 000000 0", pending, irq_req); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_service_arrival();
        test_priority();
        test_mask();
        test_illegal();
        test_gie_withdraw();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
